// File: rtl/triangle_pkg.sv
// Shared types for the triangle generator/checker pair.
package triangle_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACQUIRE,
      TRACK_UP,
      TRACK_DOWN
   } tri_state_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } tri_dir_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_V = '1;

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != MAX_V)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/triangle_checker.sv
// Locks onto a +/-1-step triangle and reports direction, extremes, half-period and step errors.
// Half-period measurement is built only when TRIANGLE_CHECKER_PERIOD_EN is defined.
module triangle_checker
   import triangle_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [N-1:0]     in,
   output logic             dir,
   output logic             locked,
   output logic             peak,
   output logic             trough,
   output logic [CNT_W-1:0] half_period,
   output logic             err,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned  XW    = N + 1;
   localparam logic [N-1:0] MAX_V = '1;

   tri_state_t   state_q, state_d;
   tri_dir_t     dir_q, dir_d;
   logic [N-1:0] prev_q, prev_d;
   logic         locked_q, locked_d;
   logic         peak_q, peak_d;
   logic         trough_q, trough_d;
   logic         err_q, err_d;

   logic         step_inc_c;
   logic         extreme_c;
   logic         track_err_c;

   // Widened by one bit so 0 <-> max never looks like a legal step.
   logic [XW-1:0] in_x, up_x, dn_x;
   assign in_x = {1'b0, in};
   assign up_x = {1'b0, prev_q} + XW'(1);
   assign dn_x = {1'b0, prev_q} - XW'(1);

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      prev_d      = prev_q;
      locked_d    = locked_q;
      peak_d      = 1'b0;
      trough_d    = 1'b0;
      err_d       = 1'b0;
      step_inc_c  = 1'b0;
      extreme_c   = 1'b0;
      track_err_c = 1'b0;

      if (ena) begin
         prev_d = in;
         unique case (state_q)
            IDLE: begin
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               if (in_x == up_x) begin
                  state_d  = TRACK_UP;
                  dir_d    = UP;
                  locked_d = 1'b1;
               end else if (in_x == dn_x) begin
                  state_d  = TRACK_DOWN;
                  dir_d    = DOWN;
                  locked_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            TRACK_UP: begin
               if (in_x == up_x) begin
                  if (in == MAX_V) begin
                     peak_d    = 1'b1;
                     extreme_c = 1'b1;
                     state_d   = TRACK_DOWN;
                     dir_d     = DOWN;
                  end else begin
                     step_inc_c = 1'b1;
                  end
               end else begin
                  err_d       = 1'b1;
                  track_err_c = 1'b1;
                  locked_d    = 1'b0;
                  state_d     = ACQUIRE;
               end
            end
            TRACK_DOWN: begin
               if (in_x == dn_x) begin
                  if (in == '0) begin
                     trough_d  = 1'b1;
                     extreme_c = 1'b1;
                     state_d   = TRACK_UP;
                     dir_d     = UP;
                  end else begin
                     step_inc_c = 1'b1;
                  end
               end else begin
                  err_d       = 1'b1;
                  track_err_c = 1'b1;
                  locked_d    = 1'b0;
                  state_d     = ACQUIRE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         dir_q    <= UP;
         prev_q   <= '0;
         locked_q <= 1'b0;
         peak_q   <= 1'b0;
         trough_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         prev_q   <= prev_d;
         locked_q <= locked_d;
         peak_q   <= peak_d;
         trough_q <= trough_d;
         err_q    <= err_d;
      end
   end

   // Counts in step with err_q, so both become visible in the same cycle.
   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_d),
      .clr   (1'b0),
      .count (err_count)
   );

`ifdef TRIANGLE_CHECKER_PERIOD_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] step_count;
   logic [CNT_W-1:0] half_period_q, half_period_d;
   logic             seen_ext_q, seen_ext_d;

   sat_counter #(.W(CNT_W)) u_step_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (step_inc_c),
      .clr   (extreme_c),
      .count (step_count)
   );

   // First extreme after lock only arms; later ones publish the step count.
   always_comb begin
      seen_ext_d    = seen_ext_q;
      half_period_d = half_period_q;
      if (track_err_c) begin
         seen_ext_d = 1'b0;
      end
      if (extreme_c) begin
         if (seen_ext_q) begin
            half_period_d = (step_count == CNT_MAX) ? CNT_MAX : step_count + CNT_W'(1);
         end
         seen_ext_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen_ext_q    <= 1'b0;
         half_period_q <= '0;
      end else begin
         seen_ext_q    <= seen_ext_d;
         half_period_q <= half_period_d;
      end
   end

   assign half_period = half_period_q;
`else
   logic unused_period_c;
   assign unused_period_c = ^{step_inc_c, extreme_c, track_err_c};
   assign half_period     = '0;
`endif

   assign dir    = dir_q;
   assign locked = locked_q;
   assign peak   = peak_q;
   assign trough = trough_q;
   assign err    = err_q;

endmodule

// File: tb/tb_triangle_checker.sv
// Scoreboard bench for triangle_checker (N=4, CNT_W=8); expectations follow TRIANGLE_CHECKER_PERIOD_EN.
module tb_triangle_checker;

   localparam int unsigned N     = 4;
   localparam int unsigned CNT_W = 8;
`ifdef TRIANGLE_CHECKER_PERIOD_EN
   localparam int HP_FULL = 15;
`else
   localparam int HP_FULL = 0;
`endif

   typedef struct packed {
      logic             dir;
      logic             locked;
      logic             peak;
      logic             trough;
      logic             err;
      logic [CNT_W-1:0] hp;
      logic [CNT_W-1:0] errc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ena = 1'b0;
   logic [N-1:0]     in = '0;
   logic             dir, locked, peak, trough, err;
   logic [CNT_W-1:0] half_period, err_count;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   // Reference model state
   int m_state, m_prev, m_dir, m_locked, m_cnt, m_seen, m_hp, m_errc;

   triangle_checker #(.N(N), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .in          (in),
      .dir         (dir),
      .locked      (locked),
      .peak        (peak),
      .trough      (trough),
      .half_period (half_period),
      .err         (err),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   function automatic exp_t observed();
      return exp_t'({dir, locked, peak, trough, err, half_period, err_count});
   endfunction

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_dir = 0; m_locked = 0;
      m_cnt = 0; m_seen = 0; m_hp = 0; m_errc = 0;
      sb.delete();
   endtask

   // Apply one sample to the model, push its expected outputs, then clock the DUT.
   task automatic drive(input bit e, input int v);
      exp_t x;
      int   i;
      bit   pk, tr, er, ext;
      pk = 0; tr = 0; er = 0; ext = 0;
      i  = v;
      if (e) begin
         case (m_state)
            0: m_state = 1;
            1: begin
               if (i == m_prev + 1) begin m_state = 2; m_dir = 0; m_locked = 1; end
               else if (i == m_prev - 1) begin m_state = 3; m_dir = 1; m_locked = 1; end
               else er = 1;
            end
            2: begin
               if (i == m_prev + 1) begin
                  if (i == 15) begin pk = 1; ext = 1; m_state = 3; m_dir = 1; end
                  else if (m_cnt < 255) m_cnt++;
               end else er = 1;
            end
            default: begin
               if (i == m_prev - 1) begin
                  if (i == 0) begin tr = 1; ext = 1; m_state = 2; m_dir = 0; end
                  else if (m_cnt < 255) m_cnt++;
               end else er = 1;
            end
         endcase
         if (er && m_state >= 2) begin m_locked = 0; m_state = 1; m_seen = 0; end
         if (ext) begin
            if (m_seen != 0) m_hp = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            m_cnt = 0; m_seen = 1;
         end
         if (er && m_errc < 255) m_errc++;
         m_prev = i;
      end
      x.dir = m_dir[0]; x.locked = m_locked[0];
      x.peak = pk; x.trough = tr; x.err = er;
`ifdef TRIANGLE_CHECKER_PERIOD_EN
      x.hp = CNT_W'(m_hp);
`else
      x.hp = '0;
`endif
      x.errc = CNT_W'(m_errc);
      sb.push_back(x);
      ena = e;
      in  = N'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      ena   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (observed() !== exp_t'(0)) begin
         errors++;
         $display("FAIL reset outputs got %h want %h", observed(), exp_t'(0));
      end
   endtask

   task automatic test_ramp();
      int   seq[$];
      exp_t e, o;
      int   n_peak, n_trough;
      apply_reset();
      for (int v = 0; v <= 15; v++) seq.push_back(v);
      for (int v = 14; v >= 0; v--) seq.push_back(v);
      seq.push_back(1);
      n_peak = 0; n_trough = 0;
      foreach (seq[k]) begin
         drive(1'b1, seq[k]);
         e = sb.pop_front();
         o = observed();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL ramp[%0d] outputs got %h want %h", k, o, e);
         end
         n_peak += int'(peak);
         n_trough += int'(trough);
         if (k == 0 || k == 1) begin
            checks++;
            if (locked !== (k == 1)) begin
               errors++;
               $display("FAIL ramp_lock[%0d] got %b want %b", k, locked, k == 1);
            end
         end
         if (k == 15 || k == 30) begin
            checks++;
            if ((k == 15 && peak !== 1'b1) || (k == 30 && trough !== 1'b1)) begin
               errors++;
               $display("FAIL ramp_extreme[%0d] got peak=%b trough=%b", k, peak, trough);
            end
         end
         if (k == 29 || k == 30) begin
            checks++;
            if (int'(half_period) != ((k == 30) ? HP_FULL : 0)) begin
               errors++;
               $display("FAIL ramp_half_period[%0d] got %0d want %0d", k, half_period,
                        (k == 30) ? HP_FULL : 0);
            end
         end
      end
      checks++;
      if (n_peak != 1 || n_trough != 1) begin
         errors++;
         $display("FAIL ramp_pulse_count got peak=%0d trough=%0d want 1 1", n_peak, n_trough);
      end
   endtask

   task automatic test_step_error();
      exp_t e;
      apply_reset();
      for (int v = 0; v <= 7; v++) begin
         drive(1'b1, v);
         e = sb.pop_front();
      end
      drive(1'b1, 9);
      e = sb.pop_front();
      checks++;
      if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || observed() !== e) begin
         errors++;
         $display("FAIL skip_error got err=%b cnt=%0d locked=%b want 1 1 0", err, err_count, locked);
      end
      drive(1'b1, 10);
      e = sb.pop_front();
      checks++;
      if (locked !== 1'b1 || dir !== 1'b0 || err !== 1'b0 || observed() !== e) begin
         errors++;
         $display("FAIL skip_relock got locked=%b dir=%b err=%b want 1 0 0", locked, dir, err);
      end
   endtask

   task automatic test_ena_hold();
      exp_t snap, e;
      snap = observed();
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, int'($urandom_range(0, 15)));
         e = sb.pop_front();
         checks++;
         if (observed() !== e || locked !== snap.locked || dir !== snap.dir ||
             err_count !== snap.errc || {peak, trough, err} !== 3'b000) begin
            errors++;
            $display("FAIL hold[%0d] got %h want %h", c, observed(), e);
         end
      end
      drive(1'b1, 11);
      e = sb.pop_front();
      checks++;
      if (err !== 1'b0 || locked !== 1'b1 || observed() !== e) begin
         errors++;
         $display("FAIL hold_resume got err=%b locked=%b want 0 1", err, locked);
      end
   endtask

   task automatic test_wrap();
      int   seq[4] = '{15, 0, 15, 14};
      exp_t e;
      apply_reset();
      foreach (seq[k]) begin
         drive(1'b1, seq[k]);
         e = sb.pop_front();
         checks++;
         if (observed() !== e) begin
            errors++;
            $display("FAIL wrap[%0d] outputs got %h want %h", k, observed(), e);
         end
         if (k == 1) begin
            checks++;
            if (err !== 1'b1 || locked !== 1'b0) begin
               errors++;
               $display("FAIL wrap_error got err=%b locked=%b want 1 0", err, locked);
            end
         end
      end
      checks++;
      if (locked !== 1'b1 || dir !== 1'b1 || peak !== 1'b0) begin
         errors++;
         $display("FAIL wrap_lock got locked=%b dir=%b peak=%b want 1 1 0", locked, dir, peak);
      end
   endtask

   task automatic test_saturate_and_reset();
      exp_t e;
      apply_reset();
      for (int c = 0; c < 301; c++) begin
         drive(1'b1, 0);
         e = sb.pop_front();
         if (c == 1 || c == 255 || c == 300) begin
            checks++;
            if (observed() !== e) begin
               errors++;
               $display("FAIL sat[%0d] outputs got %h want %h", c, observed(), e);
            end
         end
      end
      checks++;
      if (err_count !== 8'd255) begin
         errors++;
         $display("FAIL sat_count got %0d want 255", err_count);
      end
      for (int v = 1; v <= 4; v++) begin
         drive(1'b1, v);
         e = sb.pop_front();
      end
      rst_n = 1'b0;
      ena   = 1'b1;
      in    = 4'd5;
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== exp_t'(0)) begin
         errors++;
         $display("FAIL midramp_reset got %h want %h", observed(), exp_t'(0));
      end
      rst_n = 1'b1;
      model_reset();
      drive(1'b1, 9);
      e = sb.pop_front();
      checks++;
      if (err !== 1'b0 || locked !== 1'b0 || observed() !== e) begin
         errors++;
         $display("FAIL post_reset_first got err=%b locked=%b want 0 0", err, locked);
      end
      drive(1'b1, 10);
      e = sb.pop_front();
      checks++;
      if (locked !== 1'b1 || observed() !== e) begin
         errors++;
         $display("FAIL post_reset_lock got %h want %h", observed(), e);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      apply_reset();
      for (int rep = 0; rep < 2; rep++) begin
         for (int k = 0; k < 30; k++) begin
            drive(1'b1, (k <= 15) ? k : 30 - k);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
               errors++;
               $display("FAIL b2b[%0d][%0d] outputs got %h want %h", rep, k, observed(), e);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ramp();
      test_step_error();
      test_ena_hold();
      test_wrap();
      test_saturate_and_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
